// File: rtl/inst_fetch_sequencer_pkg.sv
// fetch_pkg: shared fetch FSM states, instruction size and fetch address legality check
package fetch_pkg;
  typedef enum logic [1:0] {FETCH, HOLD, FAULT} state_t;
  localparam int unsigned INST_BYTES = 4;
  function automatic logic addr_ok(input logic [63:0] a, input logic [63:0] mem_bytes);
    return a[1:0] == 2'b00 && a <= mem_bytes - 64'(INST_BYTES);
  endfunction
endpackage

// File: rtl/inst_byte_assembler.sv
// inst_byte_assembler: 4-lane byte register with lane select, load enable and clear
module inst_byte_assembler (
  input  logic        clk,
  input  logic        clr,
  input  logic        ld,
  input  logic [1:0]  lane,
  input  logic [7:0]  din,
  output logic [31:0] q
);
  always_ff @(posedge clk)
    if (clr) q <= '0;
    else if (ld) q[8*lane +: 8] <= din;
endmodule

// File: rtl/inst_fetch_sequencer.sv
// inst_fetch_sequencer: byte-serial instruction fetch with decode handshake, redirects and fault flag
module inst_fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 16,
  parameter logic [63:0] RESET_PC  = 64'd0
) (
  input  logic        clk,
  input  logic        reset,
  output logic [63:0] Mem_Addr,
  output logic        Mem_Rd_En,
  input  logic [7:0]  Mem_Rd_Data,
  input  logic        Branch_Taken,
  input  logic [63:0] Branch_Target,
  output logic        Inst_Valid,
  input  logic        Inst_Ready,
  output logic [31:0] Instruction,
  output logic [63:0] Inst_PC,
  output logic        Inst_Fault
);
  state_t state;
  logic [63:0] pc, next_pc;
  logic [1:0] cnt;
  logic cap;
  assign Mem_Addr = pc + 64'(cnt);
  assign next_pc = pc + 64'(INST_BYTES);
  assign cap = state == FETCH && Mem_Rd_En && !Branch_Taken;
  inst_byte_assembler u_asm (
    .clk  (clk),
    .clr  (!reset || Branch_Taken),
    .ld   (cap),
    .lane (cnt),
    .din  (Mem_Rd_Data),
    .q    (Instruction)
  );
  always_ff @(posedge clk)
    if (!reset) begin
      state      <= FETCH;
      pc         <= RESET_PC;
      cnt        <= '0;
      Inst_PC    <= '0;
      Inst_Valid <= 1'b0;
      Inst_Fault <= 1'b0;
      Mem_Rd_En  <= 1'b0;
    end else if (Branch_Taken) begin
      cnt        <= '0;
      Inst_Valid <= 1'b0;
      if (addr_ok(Branch_Target, 64'(MEM_BYTES))) begin
        pc         <= Branch_Target;
        state      <= FETCH;
        Inst_Fault <= 1'b0;
        Mem_Rd_En  <= 1'b1;
      end else begin
        state      <= FAULT;
        Inst_Fault <= 1'b1;
        Mem_Rd_En  <= 1'b0;
      end
    end else begin
      case (state)
        FETCH: begin
          Mem_Rd_En <= !(Mem_Rd_En && cnt == 2'd3);
          if (Mem_Rd_En) begin
            cnt <= cnt + 2'd1;
            if (cnt == 2'd3) begin
              state      <= HOLD;
              Inst_PC    <= pc;
              Inst_Valid <= 1'b1;
            end
          end
        end
        HOLD:
          if (Inst_Ready) begin
            Inst_Valid <= 1'b0;
            if (addr_ok(next_pc, 64'(MEM_BYTES))) begin
              pc        <= next_pc;
              state     <= FETCH;
              Mem_Rd_En <= 1'b1;
            end else begin
              state      <= FAULT;
              Inst_Fault <= 1'b1;
            end
          end
        default: ;
      endcase
    end
endmodule

// File: tb/tb_inst_fetch_sequencer.sv
// tb_inst_fetch_sequencer: directed self-checking bench for inst_fetch_sequencer
module tb_inst_fetch_sequencer;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [63:0] Mem_Addr, Inst_PC;
  logic [63:0] Branch_Target = '0;
  logic Mem_Rd_En, Inst_Valid, Inst_Fault;
  logic Branch_Taken = 1'b0;
  logic Inst_Ready = 1'b1;
  logic [7:0] Mem_Rd_Data;
  logic [31:0] Instruction;
  logic [7:0] mem [16];
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  assign Mem_Rd_Data = Mem_Addr < 64'd16 ? mem[Mem_Addr[3:0]] : 8'h00;
  inst_fetch_sequencer #(.MEM_BYTES(16), .RESET_PC(64'd0)) dut (
    .clk           (clk),
    .reset         (reset),
    .Mem_Addr      (Mem_Addr),
    .Mem_Rd_En     (Mem_Rd_En),
    .Mem_Rd_Data   (Mem_Rd_Data),
    .Branch_Taken  (Branch_Taken),
    .Branch_Target (Branch_Target),
    .Inst_Valid    (Inst_Valid),
    .Inst_Ready    (Inst_Ready),
    .Instruction   (Instruction),
    .Inst_PC       (Inst_PC),
    .Inst_Fault    (Inst_Fault)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic chk_inst(input string tag, input logic [31:0] ins, input logic [63:0] pc);
    chk({tag, "_valid"}, 64'(Inst_Valid), 64'd1);
    chk({tag, "_inst"}, 64'(Instruction), 64'(ins));
    chk({tag, "_pc"}, Inst_PC, pc);
    chk({tag, "_rden"}, 64'(Mem_Rd_En), 64'd0);
  endtask
  task automatic chk_rst(input string tag);
    chk({tag, "_valid"}, 64'(Inst_Valid), 64'd0);
    chk({tag, "_fault"}, 64'(Inst_Fault), 64'd0);
    chk({tag, "_rden"}, 64'(Mem_Rd_En), 64'd0);
    chk({tag, "_inst"}, 64'(Instruction), 64'd0);
    chk({tag, "_pc"}, Inst_PC, 64'd0);
    chk({tag, "_addr"}, Mem_Addr, 64'd0);
  endtask
  initial begin
    mem = '{8'h93, 8'h83, 8'hA6, 8'hAB, 8'hCC, 8'h55, 8'hA9, 8'hE3,
            8'h26, 8'hFF, 8'hCD, 8'h85, 8'h0F, 8'h43, 8'hFE, 8'h00};
    tick(1);
    chk_rst("reset");
    reset = 1'b1;
    tick(1);
    chk("c1_rden", 64'(Mem_Rd_En), 64'd1);
    chk("c1_addr", Mem_Addr, 64'd0);
    tick(3);
    chk("c4_addr", Mem_Addr, 64'd3);
    chk("c4_valid", 64'(Inst_Valid), 64'd0);
    tick(1);
    chk_inst("i0", 32'hABA68393, 64'd0);
    tick(1);
    chk("c6_valid", 64'(Inst_Valid), 64'd0);
    chk("c6_addr", Mem_Addr, 64'd4);
    tick(4);
    chk_inst("i1", 32'hE3A955CC, 64'd4);
    tick(5);
    chk_inst("i2", 32'h85CDFF26, 64'd8);
    tick(5);
    chk_inst("i3", 32'h00FE430F, 64'd12);
    tick(1);
    chk("oor_fault", 64'(Inst_Fault), 64'd1);
    chk("oor_valid", 64'(Inst_Valid), 64'd0);
    chk("oor_rden", 64'(Mem_Rd_En), 64'd0);
    Branch_Taken = 1'b1;
    Branch_Target = 64'd4;
    tick(1);
    chk("clr_fault", 64'(Inst_Fault), 64'd0);
    chk("clr_rden", 64'(Mem_Rd_En), 64'd1);
    chk("clr_addr", Mem_Addr, 64'd4);
    Branch_Taken = 1'b0;
    Inst_Ready = 1'b0;
    tick(4);
    chk_inst("rec", 32'hE3A955CC, 64'd4);
    tick(10);
    chk_inst("stall", 32'hE3A955CC, 64'd4);
    Inst_Ready = 1'b1;
    tick(1);
    chk("rel_valid", 64'(Inst_Valid), 64'd0);
    chk("rel_addr", Mem_Addr, 64'd8);
    tick(4);
    chk_inst("rel", 32'h85CDFF26, 64'd8);
    Branch_Taken = 1'b1;
    Branch_Target = 64'd0;
    tick(1);
    chk("hsbr_valid", 64'(Inst_Valid), 64'd0);
    chk("hsbr_addr", Mem_Addr, 64'd0);
    Branch_Taken = 1'b0;
    tick(1);
    chk("f2_addr", Mem_Addr, 64'd1);
    Branch_Taken = 1'b1;
    Branch_Target = 64'd12;
    tick(1);
    chk("midbr_addr", Mem_Addr, 64'd12);
    chk("midbr_valid", 64'(Inst_Valid), 64'd0);
    Branch_Taken = 1'b0;
    Inst_Ready = 1'b0;
    tick(4);
    chk_inst("midbr", 32'h00FE430F, 64'd12);
    Branch_Taken = 1'b1;
    Branch_Target = 64'd6;
    tick(1);
    chk("mis_fault", 64'(Inst_Fault), 64'd1);
    chk("mis_valid", 64'(Inst_Valid), 64'd0);
    chk("mis_addr", Mem_Addr, 64'd12);
    Branch_Target = 64'd16;
    tick(1);
    chk("big_fault", 64'(Inst_Fault), 64'd1);
    chk("big_addr", Mem_Addr, 64'd12);
    Branch_Target = 64'd4;
    tick(1);
    chk("leg_fault", 64'(Inst_Fault), 64'd0);
    chk("leg_addr", Mem_Addr, 64'd4);
    Branch_Taken = 1'b0;
    tick(4);
    chk_inst("leg", 32'hE3A955CC, 64'd4);
    Inst_Ready = 1'b1;
    Branch_Taken = 1'b1;
    Branch_Target = 64'd0;
    tick(1);
    chk("rdybr_valid", 64'(Inst_Valid), 64'd0);
    chk("rdybr_addr", Mem_Addr, 64'd0);
    chk("rdybr_fault", 64'(Inst_Fault), 64'd0);
    Branch_Taken = 1'b0;
    tick(4);
    chk_inst("rdybr", 32'hABA68393, 64'd0);
    tick(3);
    chk("pre_rst_addr", Mem_Addr, 64'd6);
    chk("pre_rst_rden", 64'(Mem_Rd_En), 64'd1);
    reset = 1'b0;
    tick(1);
    chk_rst("midrst");
    reset = 1'b1;
    tick(1);
    chk("rst_c1_rden", 64'(Mem_Rd_En), 64'd1);
    chk("rst_c1_addr", Mem_Addr, 64'd0);
    tick(4);
    chk_inst("after_rst", 32'hABA68393, 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
